// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD timer slice.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t d2;
        bcd_digit_t d1;
        bcd_digit_t d0;
    } bcd3_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tmr_state_e;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction

    // Any out-of-range value folds back to 0, so a digit never settles above 9.
    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d >= BCD_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: counts 0..9 when enabled, flags 9 for the carry chain.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       at_max
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= bcd_inc(q);
        end
    end

    assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run-control sequencer for a 3-digit BCD count chain: prescaler, commands,
// target match, lap snapshot and done state.
module bcd_timer_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned WRAP     = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    input  logic [11:0] target,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [11:0] lap_bcd,
    output logic        lap_valid,
    output logic        tick,
    output logic        running,
    output logic        paused,
    output logic        done
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    tmr_state_e state, state_n;
    logic [15:0] pre_cnt;
    bcd3_t       target_q;
    bcd3_t       lap_q;
    logic        lap_v;

    logic [3:0]  q0, q1, q2;
    logic        max0, max1, max2;
    logic        tick_i, terminal, hit, tgt_ok;
    logic        en0, en1, en2;
    bcd3_t       cnt, cnt_inc;

    assign cnt = '{d2: q2, d1: q1, d0: q0};

    always_comb begin
        tick_i   = (state == RUN) && (pre_cnt == PRE_LAST);
        terminal = tick_i && max0 && max1 && max2 && (WRAP == 0);
        // A terminal tick is a count hold, so the chain is not enabled at all.
        en0      = tick_i && !terminal;
        en1      = en0 && max0;
        en2      = en1 && max1;
        cnt_inc  = cnt;
        if (en0) cnt_inc.d0 = bcd_inc(cnt.d0);
        if (en1) cnt_inc.d1 = bcd_inc(cnt.d1);
        if (en2) cnt_inc.d2 = bcd_inc(cnt.d2);
        tgt_ok   = bcd_valid(target_q.d0) && bcd_valid(target_q.d1) && bcd_valid(target_q.d2);
        hit      = tick_i && tgt_ok && (cnt_inc == target_q);
    end

    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_n = RUN;
                RUN: begin
                    if (hit || terminal) state_n = DONE;
                    else if (stop)       state_n = PAUSE;
                end
                PAUSE:   if (start) state_n = RUN;
                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pre_cnt <= '0;
        end else if (state == IDLE && start) begin
            pre_cnt <= '0;
        end else if (state == RUN) begin
            pre_cnt <= tick_i ? '0 : pre_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= '0;
        end else if (!clear && state == IDLE && start) begin
            target_q <= target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lap_q <= '0;
            lap_v <= 1'b0;
        end else if (lap && (state == RUN || state == PAUSE)) begin
            lap_q <= cnt;
            lap_v <= 1'b1;
        end
    end

    bcd_digit_cell u_d0 (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear),
        .en     (en0),
        .q      (q0),
        .at_max (max0)
    );

    bcd_digit_cell u_d1 (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear),
        .en     (en1),
        .q      (q1),
        .at_max (max1)
    );

    bcd_digit_cell u_d2 (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear),
        .en     (en2),
        .q      (q2),
        .at_max (max2)
    );

    assign digit0    = q0;
    assign digit1    = q1;
    assign digit2    = q2;
    assign lap_bcd   = lap_q;
    assign lap_valid = lap_v;
    assign tick      = tick_i;
    assign running   = (state == RUN);
    assign paused    = (state == PAUSE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench: three parameterisations of bcd_timer_ctrl checked
// against a decimal-arithmetic model plus a vector table and corner sequences.
module tb_bcd_timer_ctrl;

    localparam int PS_T [3] = '{4, 1, 1};
    localparam int WR_T [3] = '{1, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst, st, sp, cl, lp;
    logic [2:0][11:0]  tg;
    logic [2:0][3:0]   d0, d1, d2;
    logic [2:0][11:0]  lb;
    logic [2:0]        lv, tk, rn, pa, dn;

    bcd_timer_ctrl #(.PRESCALE(4), .WRAP(1)) dut0 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .stop(sp[0]), .clear(cl[0]), .lap(lp[0]),
        .target(tg[0]), .digit0(d0[0]), .digit1(d1[0]), .digit2(d2[0]), .lap_bcd(lb[0]),
        .lap_valid(lv[0]), .tick(tk[0]), .running(rn[0]), .paused(pa[0]), .done(dn[0]));

    bcd_timer_ctrl #(.PRESCALE(1), .WRAP(1)) dut1 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .stop(sp[1]), .clear(cl[1]), .lap(lp[1]),
        .target(tg[1]), .digit0(d0[1]), .digit1(d1[1]), .digit2(d2[1]), .lap_bcd(lb[1]),
        .lap_valid(lv[1]), .tick(tk[1]), .running(rn[1]), .paused(pa[1]), .done(dn[1]));

    bcd_timer_ctrl #(.PRESCALE(1), .WRAP(0)) dut2 (
        .clk(clk), .reset(rst[2]), .start(st[2]), .stop(sp[2]), .clear(cl[2]), .lap(lp[2]),
        .target(tg[2]), .digit0(d0[2]), .digit1(d1[2]), .digit2(d2[2]), .lap_bcd(lb[2]),
        .lap_valid(lv[2]), .tick(tk[2]), .running(rn[2]), .paused(pa[2]), .done(dn[2]));

    int checks = 0;
    int failures = 0;

    // Model state: 0 idle, 1 run, 2 pause, 3 done; counts held as plain integers.
    int m_st [3], m_cnt [3], m_pre [3], m_tgt [3], m_lapc [3];
    bit m_lapv [3];

    function automatic logic [11:0] int2bcd(input int c);
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic int bcd2int(input logic [11:0] b);
        if (b[11:8] > 4'd9 || b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic void model_step(input int k);
        bit tkm, hit, term;
        int nst, nc;
        tkm = (m_st[k] == 1) && (m_pre[k] == PS_T[k] - 1);
        if (rst[k]) begin
            m_st[k] = 0; m_cnt[k] = 0; m_pre[k] = 0; m_tgt[k] = 0; m_lapc[k] = 0; m_lapv[k] = 0;
        end else if (cl[k]) begin
            m_st[k] = 0; m_cnt[k] = 0; m_pre[k] = 0; m_lapc[k] = 0; m_lapv[k] = 0;
        end else begin
            nst = m_st[k];
            hit = 0; term = 0;
            if (lp[k] && (m_st[k] == 1 || m_st[k] == 2)) begin
                m_lapc[k] = m_cnt[k];
                m_lapv[k] = 1;
            end
            if (tkm) begin
                nc = m_cnt[k] + 1;
                if (nc == 1000) begin
                    if (WR_T[k] != 0) nc = 0;
                    else begin nc = 999; term = 1; end
                end
                hit = (nc == m_tgt[k]);
                m_cnt[k] = nc;
                m_pre[k] = 0;
            end else if (m_st[k] == 1) begin
                m_pre[k] = m_pre[k] + 1;
            end
            if (m_st[k] == 1 && sp[k]) nst = 2;
            else if (m_st[k] == 0 && st[k]) begin
                nst = 1; m_tgt[k] = bcd2int(tg[k]); m_pre[k] = 0;
            end else if (m_st[k] == 2 && st[k]) nst = 1;
            if (tkm && (hit || term)) nst = 3;
            m_st[k] = nst;
        end
    endfunction

    function automatic logic [28:0] act_vec(input int k);
        return {d2[k], d1[k], d0[k], lb[k], lv[k], tk[k], rn[k], pa[k], dn[k]};
    endfunction

    function automatic logic [28:0] exp_vec(input int k);
        logic etk;
        etk = (m_st[k] == 1) && (m_pre[k] == PS_T[k] - 1);
        return {int2bcd(m_cnt[k]), int2bcd(m_lapc[k]), m_lapv[k], etk,
                m_st[k] == 1, m_st[k] == 2, m_st[k] == 3};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared at the following negedge.
    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("model%0d", k), 32'(act_vec(k)), 32'(exp_vec(k)));
    endtask

    task automatic pulse(input int k, input logic s, input logic p, input logic c,
                         input logic l, input logic [11:0] t);
        st[k] = s; sp[k] = p; cl[k] = c; lp[k] = l; tg[k] = t;
        cyc();
        st[k] = 0; sp[k] = 0; cl[k] = 0; lp[k] = 0;
    endtask

    task automatic run_to(input int k, input logic [11:0] val, input int budget, input string nm);
        int n;
        n = 0;
        while ({d2[k], d1[k], d0[k]} !== val && n < budget) begin
            cyc();
            n++;
        end
        chk(nm, {d2[k], d1[k], d0[k]}, val);
    endtask

    typedef struct {
        logic s, p, c, l;
        logic [11:0] t;
        logic [11:0] cnt, lapv;
        logic [4:0] flags;   // {lap_valid, tick, running, paused, done}
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [11:0] saved;

        tbl[0]  = '{1, 0, 0, 0, 12'h003, 12'h000, 12'h000, 5'b01100};
        tbl[1]  = '{0, 0, 0, 0, 12'h003, 12'h001, 12'h000, 5'b01100};
        tbl[2]  = '{0, 0, 0, 1, 12'h003, 12'h002, 12'h001, 5'b11100};
        tbl[3]  = '{0, 0, 0, 0, 12'h003, 12'h003, 12'h001, 5'b10001};
        tbl[4]  = '{1, 0, 0, 0, 12'h003, 12'h003, 12'h001, 5'b10001};
        tbl[5]  = '{0, 0, 1, 0, 12'h003, 12'h000, 12'h000, 5'b00000};
        tbl[6]  = '{1, 0, 0, 0, 12'h100, 12'h000, 12'h000, 5'b01100};
        tbl[7]  = '{0, 1, 0, 0, 12'h100, 12'h001, 12'h000, 5'b00010};
        tbl[8]  = '{0, 0, 0, 1, 12'h100, 12'h001, 12'h001, 5'b10010};
        tbl[9]  = '{1, 0, 0, 0, 12'h100, 12'h001, 12'h001, 5'b11100};
        tbl[10] = '{1, 0, 1, 1, 12'hFFF, 12'h000, 12'h000, 5'b00000};

        rst = '1; st = '0; sp = '0; cl = '0; lp = '0; tg = '0;
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_pre[k] = 0; m_tgt[k] = 0; m_lapc[k] = 0; m_lapv[k] = 0;
        end
        @(negedge clk);
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) chk($sformatf("reset%0d", k), 32'(act_vec(k)), 32'd0);
        rst = '0;

        // Vector table on the PRESCALE=1 / WRAP=1 instance.
        for (int i = 0; i < 11; i++) begin
            pulse(1, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l, tbl[i].t);
            chk($sformatf("tbl%0d_cnt", i), {d2[1], d1[1], d0[1]}, tbl[i].cnt);
            chk($sformatf("tbl%0d_lap", i), lb[1], tbl[i].lapv);
            chk($sformatf("tbl%0d_flags", i), {lv[1], tk[1], rn[1], pa[1], dn[1]}, tbl[i].flags);
        end

        // Target 012 at PRESCALE=4: done lands 48 edges after the start edge.
        pulse(0, 1, 0, 0, 0, 12'h012);
        n = 0;
        while (!dn[0] && n < 60) begin cyc(); n++; end
        chk("t1_latency", n, 48);
        chk("t1_state", {d2[0], d1[0], d0[0], rn[0], dn[0]}, {12'h012, 2'b01});
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t1_hold", {d2[0], d1[0], d0[0], tk[0], dn[0]}, {12'h012, 2'b01});
        end

        // Carry ripple with an invalid (never-matching) target.
        pulse(1, 0, 0, 1, 0, 12'hFFF);
        pulse(1, 1, 0, 0, 0, 12'hFFF);
        run_to(1, 12'h009, 20, "t2_reach009");
        cyc(); chk("t2_carry010", {d2[1], d1[1], d0[1]}, 12'h010);
        run_to(1, 12'h099, 200, "t2_reach099");
        cyc(); chk("t2_carry100", {d2[1], d1[1], d0[1]}, 12'h100);
        run_to(1, 12'h999, 1000, "t2_reach999");
        cyc(); chk("t2_wrap000", {d2[1], d1[1], d0[1], dn[1]}, {12'h000, 1'b0});

        // WRAP=0 terminal count.
        pulse(2, 1, 0, 0, 0, 12'hFFF);
        n = 0;
        while (!dn[2] && n < 1100) begin cyc(); n++; end
        chk("t3_latency", n, 1000);
        chk("t3_hold", {d2[2], d1[2], d0[2], dn[2]}, {12'h999, 1'b1});
        cyc(); cyc();
        pulse(2, 1, 0, 0, 0, 12'hFFF);
        chk("t3_start_ignored", {d2[2], d1[2], d0[2], rn[2], dn[2]}, {12'h999, 2'b01});
        pulse(2, 0, 0, 1, 0, 12'hFFF);
        chk("t3_clear", {d2[2], d1[2], d0[2], rn[2], pa[2], dn[2]}, 15'd0);

        // Pause with prescaler frozen at 2, then resume.
        pulse(0, 0, 0, 1, 0, 12'hFFF);
        pulse(0, 1, 0, 0, 0, 12'hFFF);
        run_to(0, 12'h003, 20, "t4_reach003");
        cyc();
        pulse(0, 0, 1, 0, 0, 12'hFFF);
        saved = {d2[0], d1[0], d0[0]};
        chk("t4_paused", {saved, pa[0], rn[0]}, {12'h003, 2'b10});
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t4_frozen", {d2[0], d1[0], d0[0], pa[0], tk[0]}, {saved, 2'b10});
        end
        pulse(0, 0, 0, 0, 1, 12'hFFF);
        chk("t4_lap", {lb[0], lv[0]}, {12'h003, 1'b1});
        pulse(0, 1, 0, 0, 0, 12'hFFF);
        chk("t4_resume1", {rn[0], tk[0]}, 2'b10);
        cyc();
        chk("t4_resume2", {rn[0], tk[0]}, 2'b11);

        // stop coinciding with a matching tick, and lap coinciding with a tick.
        pulse(1, 0, 0, 1, 0, 12'h005);
        pulse(1, 1, 0, 0, 0, 12'h005);
        run_to(1, 12'h004, 20, "t5_reach004");
        pulse(1, 0, 1, 0, 0, 12'h005);
        chk("t5_stop_vs_done", {d2[1], d1[1], d0[1], pa[1], dn[1]}, {12'h005, 2'b01});
        pulse(1, 0, 0, 1, 0, 12'hFFF);
        pulse(1, 1, 0, 0, 0, 12'hFFF);
        run_to(1, 12'h041, 100, "t5_reach041");
        pulse(1, 0, 0, 0, 1, 12'hFFF);
        chk("t5_lap_tick", {lb[1], d2[1], d1[1], d0[1]}, {12'h041, 12'h042});

        // Reset in mid-run.
        pulse(1, 0, 0, 1, 0, 12'hFFF);
        pulse(1, 1, 0, 0, 0, 12'hFFF);
        run_to(1, 12'h100, 200, "t6_reach100");
        pulse(1, 0, 0, 0, 1, 12'hFFF);
        run_to(1, 12'h357, 400, "t6_reach357");
        chk("t6_lapv", lv[1], 1);
        rst[1] = 1;
        cyc();
        rst[1] = 0;
        chk("t6_reset", 32'(act_vec(1)), 32'd0);
        pulse(1, 1, 0, 0, 0, 12'hFFF);
        chk("t6_restart0", {d2[1], d1[1], d0[1], rn[1]}, {12'h000, 1'b1});
        cyc();
        chk("t6_restart1", {d2[1], d1[1], d0[1]}, 12'h001);

        // Random command mix on all instances, checked by the model every cycle.
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < 3; k++) begin
                rst[k] = ($urandom_range(0, 299) == 0);
                st[k]  = ($urandom_range(0, 7) == 0);
                sp[k]  = ($urandom_range(0, 15) == 0);
                cl[k]  = ($urandom_range(0, 63) == 0);
                lp[k]  = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) tg[k] = 12'($urandom);
                else tg[k] = int2bcd(int'($urandom_range(0, 60)));
            end
            cyc();
        end
        rst = '0; st = '0; sp = '0; cl = '0; lp = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
